viterbi_stream_decoder: RTL and testbench



---
 rtl/viterbi_stream_decoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_viterbi_stream_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_stream_decoder.sv
// Rate-1/2 Viterbi decoder core: serial ACS over a two-bank metric store, circular survivor
// memory, sliding-window traceback and end-of-frame flush behind valid/ready streams.

module viterbi_stream_decoder #(
    parameter int unsigned K      = 5,
    parameter int unsigned D_TB   = 32,
    parameter int unsigned G0_OCT = 'o23,
    parameter int unsigned G1_OCT = 'o35,
    parameter int unsigned SW     = 3,
    parameter int unsigned PM_W   = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [SW-1:0] i_in_sym0,
    input  logic [SW-1:0] i_in_sym1,
    input  logic          i_in_last,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_out_bit,
    output logic          o_out_last,
    output logic          o_busy
);

    localparam int unsigned NS  = 1 << (K - 1);
    localparam int unsigned SBW = K - 1;
    localparam int unsigned RW  = $clog2(D_TB);
    localparam int unsigned CW  = $clog2(D_TB + 1);
    localparam int unsigned BMW = SW + 1;

    localparam logic [K-1:0]    G0      = G0_OCT[K-1:0];
    localparam logic [K-1:0]    G1      = G1_OCT[K-1:0];
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);

    typedef enum logic [2:0] {
        StIdle,
        StAcs,
        StTb,
        StOut,
        StFlushTb,
        StFlushOut
    } state_e;

    // Distance of a soft pair from the coded bits of encoder register r.
    function automatic logic [BMW-1:0] branch_metric(input logic [K-1:0]  r,
                                                     input logic [SW-1:0] s0,
                                                     input logic [SW-1:0] s1);
        logic [SW-1:0] m0;
        logic [SW-1:0] m1;
        m0 = (^(r & G0)) ? ~s0 : s0;
        m1 = (^(r & G1)) ? ~s1 : s1;
        return {1'b0, m0} + {1'b0, m1};
    endfunction

    state_e          r_state;
    logic            r_bank;
    logic [PM_W-1:0] r_pm [2][NS];
    logic [NS-1:0]   r_dec [D_TB];
    logic [SW-1:0]   r_sym0;
    logic [SW-1:0]   r_sym1;
    logic            r_last;
    logic [SBW-1:0]  r_n;
    logic [PM_W-1:0] r_best_pm;
    logic [SBW-1:0]  r_best_st;
    logic [SBW-1:0]  r_tb_st;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   r_wptr;
    logic [RW-1:0]   r_step;
    logic [RW-1:0]   r_fidx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_flen;
    logic [D_TB-1:0] r_fbuf;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_out_bit;
    logic            r_out_last;
    logic            r_busy;

    logic [SBW-1:0]  w_p0;
    logic [SBW-1:0]  w_p1;
    logic [PM_W-1:0] w_cand0;
    logic [PM_W-1:0] w_cand1;
    logic [PM_W-1:0] w_diff;
    logic            w_dec;
    logic [PM_W-1:0] w_new_pm;
    logic [PM_W-1:0] w_best_diff;
    logic            w_take;
    logic [SBW-1:0]  w_tb_prev;
    logic            w_tb_bit;
    logic [RW-1:0]   w_row_prev;
    logic [RW-1:0]   w_wptr_inc;
    logic [CW-1:0]   w_cnt_inc;
    logic [RW-1:0]   w_fidx_nxt;

    assign w_p0    = {r_n[SBW-2:0], 1'b0};
    assign w_p1    = {r_n[SBW-2:0], 1'b1};
    assign w_cand0 = r_pm[r_bank][w_p0]
                     + PM_W'(branch_metric({r_n[SBW-1], w_p0}, r_sym0, r_sym1));
    assign w_cand1 = r_pm[r_bank][w_p1]
                     + PM_W'(branch_metric({r_n[SBW-1], w_p1}, r_sym0, r_sym1));

    // Modulo compare: the sign of the wrapped difference decides, ties keep x=0.
    assign w_diff      = w_cand0 - w_cand1;
    assign w_dec       = !w_diff[PM_W-1] && (w_diff != '0);
    assign w_new_pm    = w_dec ? w_cand1 : w_cand0;
    assign w_best_diff = w_new_pm - r_best_pm;
    assign w_take      = (r_n == '0) || w_best_diff[PM_W-1];

    assign w_tb_bit   = r_tb_st[SBW-1];
    assign w_tb_prev  = {r_tb_st[SBW-2:0], r_dec[r_row][r_tb_st]};
    assign w_row_prev = (r_row == '0) ? RW'(D_TB - 1) : r_row - 1'b1;
    assign w_wptr_inc = (r_wptr == RW'(D_TB - 1)) ? '0 : r_wptr + 1'b1;
    assign w_cnt_inc  = (r_cnt == CW'(D_TB)) ? r_cnt : r_cnt + 1'b1;
    assign w_fidx_nxt = r_fidx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_bank      <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                r_pm[0][s] <= (s == 0) ? '0 : PM_INIT;
                r_pm[1][s] <= (s == 0) ? '0 : PM_INIT;
            end
            r_sym0      <= '0;
            r_sym1      <= '0;
            r_last      <= 1'b0;
            r_n         <= '0;
            r_best_pm   <= '0;
            r_best_st   <= '0;
            r_tb_st     <= '0;
            r_row       <= '0;
            r_wptr      <= '0;
            r_step      <= '0;
            r_fidx      <= '0;
            r_cnt       <= '0;
            r_flen      <= '0;
            r_fbuf      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_sym0     <= i_in_sym0;
                        r_sym1     <= i_in_sym1;
                        r_last     <= i_in_last;
                        r_n        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StAcs;
                    end
                end
                StAcs: begin
                    r_pm[~r_bank][r_n]   <= w_new_pm;
                    r_dec[r_wptr][r_n]   <= w_dec;
                    r_n                  <= r_n + 1'b1;
                    if (w_take) begin
                        r_best_pm <= w_new_pm;
                        r_best_st <= r_n;
                    end
                    if (r_n == SBW'(NS - 1)) begin
                        r_bank  <= ~r_bank;
                        r_wptr  <= w_wptr_inc;
                        r_cnt   <= w_cnt_inc;
                        r_row   <= r_wptr;
                        r_tb_st <= w_take ? r_n : r_best_st;
                        if (r_last) begin
                            r_step  <= RW'(w_cnt_inc - 1'b1);
                            r_flen  <= w_cnt_inc;
                            r_state <= StFlushTb;
                        end else if (w_cnt_inc == CW'(D_TB)) begin
                            r_step  <= RW'(D_TB - 1);
                            r_state <= StTb;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= StIdle;
                        end
                    end
                end
                StTb, StFlushTb: begin
                    r_tb_st <= w_tb_prev;
                    r_row   <= w_row_prev;
                    r_step  <= r_step - 1'b1;
                    // Bits come out newest-first; store them so index 0 is the oldest.
                    if (r_state == StFlushTb) begin
                        r_fbuf[r_step] <= w_tb_bit;
                    end
                    if (r_step == '0) begin
                        r_out_valid <= 1'b1;
                        r_out_bit   <= w_tb_bit;
                        if (r_state == StFlushTb) begin
                            r_fidx     <= '0;
                            r_out_last <= (r_flen == CW'(1));
                            r_state    <= StFlushOut;
                        end else begin
                            r_state <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StFlushOut: begin
                    if (i_out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_bank      <= 1'b0;
                            for (int s = 0; s < NS; s++) begin
                                r_pm[0][s] <= (s == 0) ? '0 : PM_INIT;
                                r_pm[1][s] <= (s == 0) ? '0 : PM_INIT;
                            end
                            r_cnt       <= '0;
                            r_wptr      <= '0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= StIdle;
                        end else begin
                            r_fidx     <= w_fidx_nxt;
                            r_out_bit  <= r_fbuf[w_fidx_nxt];
                            r_out_last <= (CW'(w_fidx_nxt) == r_flen - 1'b1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_bit   = r_out_bit;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Randomised frame-level bench for viterbi_stream_decoder: encodes data, drives frames and
// compares decoded streams against the source data or an array-based Viterbi model.

module tb_viterbi_stream_decoder;

    localparam int K      = 5;
    localparam int D_TB   = 32;
    localparam int SW     = 3;
    localparam int PM_W   = 10;
    localparam int NS     = 1 << (K - 1);
    localparam int G0     = 'o23;
    localparam int G1     = 'o35;
    localparam int SMAX   = (1 << SW) - 1;
    localparam int MASK   = (1 << PM_W) - 1;
    localparam int HALF   = 1 << (PM_W - 1);
    localparam int T_SLOW = 1 + NS + D_TB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sym0;
    logic [SW-1:0] in_sym1;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    viterbi_stream_decoder #(
        .K(K), .D_TB(D_TB), .G0_OCT(G0), .G1_OCT(G1), .SW(SW), .PM_W(PM_W)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_sym0   (in_sym0),
        .i_in_sym1   (in_sym1),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_bit   (out_bit),
        .o_out_last  (out_last),
        .o_busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int q_s0[$];
    int q_s1[$];
    bit q_data[$];
    bit q_exp[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int parity(input int v);
        return $countones(v) & 1;
    endfunction

    function automatic int bm(input int r, input int b);
        return b ? (SMAX - r) : r;
    endfunction

    function automatic bit is_neg(input int v);
        return (v & MASK) >= HALF;
    endfunction

    // Hard 0/SMAX symbols for q_data; noisy=1 blends in weak and random soft values.
    function automatic void encode(input bit noisy);
        int s = 0;
        q_s0.delete();
        q_s1.delete();
        foreach (q_data[i]) begin
            int r = (int'(q_data[i]) << (K - 1)) | s;
            int a = parity(r & G0) ? SMAX : 0;
            int b = parity(r & G1) ? SMAX : 0;
            if (noisy) begin
                int p = $urandom_range(0, 99);
                if (p < 15) a = $urandom_range(3, 4);
                else if (p < 25) a = $urandom_range(0, SMAX);
                p = $urandom_range(0, 99);
                if (p < 15) b = $urandom_range(3, 4);
                else if (p < 25) b = $urandom_range(0, SMAX);
            end
            q_s0.push_back(a);
            q_s1.push_back(b);
            s = r >> 1;
        end
    endfunction

    // Reference decoder over the whole frame history in absolute time.
    function automatic void model_frame();
        int          pm[NS];
        int          npm[NS];
        bit [NS-1:0] hist[$];
        int          f = q_s0.size();
        int          best;
        int          s;
        bit          tmp[$];
        q_exp.delete();
        for (int n = 0; n < NS; n++) pm[n] = (n == 0) ? 0 : (1 << (PM_W - 2));
        for (int t = 0; t < f; t++) begin
            bit [NS-1:0] d = '0;
            for (int n = 0; n < NS; n++) begin
                int cand[2];
                for (int x = 0; x < 2; x++) begin
                    int p = ((n << 1) | x) & (NS - 1);
                    int r = (((n >> (K - 2)) & 1) << (K - 1)) | p;
                    cand[x] = (pm[p] + bm(q_s0[t], parity(r & G0))
                               + bm(q_s1[t], parity(r & G1))) & MASK;
                end
                if (is_neg(cand[0] - cand[1]) || cand[0] == cand[1]) begin
                    npm[n] = cand[0];
                end else begin
                    npm[n] = cand[1];
                    d[n] = 1'b1;
                end
            end
            best = 0;
            for (int n = 1; n < NS; n++) if (is_neg(npm[n] - npm[best])) best = n;
            pm = npm;
            hist.push_back(d);
            if (t == f - 1 || t + 1 >= D_TB) begin
                int steps = (t == f - 1) ? ((t + 1 < D_TB) ? t + 1 : D_TB) : D_TB;
                s = best;
                tmp.delete();
                for (int i = 0; i < steps; i++) begin
                    tmp.push_front(bit'((s >> (K - 2)) & 1));
                    s = ((s << 1) & (NS - 1)) | int'(hist[t - i][s]);
                end
                if (t == f - 1) foreach (tmp[i]) q_exp.push_back(tmp[i]);
                else q_exp.push_back(tmp[0]);
            end
        end
    endfunction

    // bp_mode: 0 always ready, 1 two 20-cycle stalls (OUT and FLUSH_OUT), 2 random.
    task automatic run_frame(input int bp_mode, input int abort_cyc, input bit chk_lat);
        int   f = q_s0.size();
        int   sent = 0;
        int   recv = 0;
        int   cyc = 0;
        int   after = 0;
        int   last_hs = -1;
        int   stall_left = 0;
        int   budget = f * 60 + 400;
        bit   pend = 0;
        bit   first_seen = 0;
        bit   stalled_a = 0;
        bit   stalled_b = 0;
        bit   aborted = 0;
        logic pb;
        logic pl;
        while (recv < f && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_bit", out_bit, pb);
                check_eq("hold_last", out_last, pl);
            end
            if (out_valid) begin
                check_eq("in_ready_low", in_ready, 0);
                check_eq("busy_during_out", busy, 1);
                if (!first_seen) begin
                    first_seen = 1;
                    check_eq("first_out_latency", sent, (f < D_TB) ? f : D_TB);
                end
            end
            if (stall_left > 0) begin
                stall_left--;
                out_ready = 1'b0;
            end else if (bp_mode == 1 && out_valid && recv == 0 && !stalled_a) begin
                stalled_a  = 1;
                stall_left = 19;
                out_ready  = 1'b0;
            end else if (bp_mode == 1 && out_valid && recv == f - D_TB + 1 && !stalled_b) begin
                stalled_b  = 1;
                stall_left = 19;
                out_ready  = 1'b0;
            end else if (bp_mode == 2) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid) begin
                if (out_ready) begin
                    check_eq("out_bit", out_bit, q_exp[recv]);
                    check_eq("out_last", out_last, recv == f - 1);
                    recv++;
                    pend = 0;
                end else begin
                    pend = 1;
                    pb   = out_bit;
                    pl   = out_last;
                end
            end
            if (sent < f) begin
                in_valid = 1'b1;
                in_sym0  = SW'(q_s0[sent]);
                in_sym1  = SW'(q_s1[sent]);
                in_last  = (sent == f - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (chk_lat && last_hs >= 0)
                    check_eq("accept_interval", cyc - last_hs,
                             (sent - 1 >= D_TB - 1) ? T_SLOW : 1 + NS);
                last_hs = cyc;
                sent++;
            end
            if (abort_cyc > 0 && sent >= D_TB) begin
                after++;
                if (after == abort_cyc) begin
                    aborted = 1;
                    break;
                end
            end
        end
        if (!aborted) check_eq("frame_complete", recv, f);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_bit"}, out_bit, 0);
        check_eq({tag, "_out_last"}, out_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [15:0] lfsr;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym0   = '0;
        in_sym1   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Noiseless LFSR frame with latency checks.
        lfsr = 16'hACE1;
        q_data.delete();
        for (int i = 0; i < 64; i++) begin
            q_data.push_back(lfsr[0]);
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
        encode(0);
        q_exp = q_data;
        run_frame(0, 0, 1);

        // Short frame 1,0,1,1,0.
        q_data = '{1, 0, 1, 1, 0};
        encode(0);
        q_exp = q_data;
        run_frame(0, 0, 1);

        // Single-pair frame.
        q_data = '{1};
        encode(0);
        q_exp = q_data;
        run_frame(0, 0, 0);

        // Three isolated symbol inversions must be corrected.
        q_data.delete();
        for (int i = 0; i < 64; i++) q_data.push_back(bit'($urandom_range(0, 1)));
        encode(0);
        q_s0[10] = SMAX - q_s0[10];
        q_s1[25] = SMAX - q_s1[25];
        q_s0[40] = SMAX - q_s0[40];
        q_exp = q_data;
        run_frame(0, 0, 0);

        // Backpressure in OUT and FLUSH_OUT.
        q_data.delete();
        for (int i = 0; i < 64; i++) q_data.push_back(bit'($urandom_range(0, 1)));
        encode(0);
        q_exp = q_data;
        run_frame(1, 0, 0);

        // Long noisy stream: metrics wrap; reference model decides.
        q_data.delete();
        for (int i = 0; i < 700; i++) q_data.push_back(bit'($urandom_range(0, 1)));
        encode(1);
        model_frame();
        run_frame(2, 0, 0);

        // Reset during sliding traceback, then a fresh short frame.
        q_data.delete();
        for (int i = 0; i < 40; i++) q_data.push_back(bit'($urandom_range(0, 1)));
        encode(0);
        q_exp = q_data;
        run_frame(0, 20, 0);
        check_eq("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        q_data.delete();
        for (int i = 0; i < 5; i++) q_data.push_back(bit'($urandom_range(0, 1)));
        encode(0);
        q_exp = q_data;
        run_frame(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
